// File: rtl/ps2_scan_decoder_pkg.sv
// Shared constants for the PS/2 scan decoder: note table, prefix bytes, FSM state type.
package ps2_pkg;

    localparam int NUM_NOTES = 12;

    localparam logic [7:0] NOTE_00 = 8'h1A;
    localparam logic [7:0] NOTE_01 = 8'h1B;
    localparam logic [7:0] NOTE_02 = 8'h22;
    localparam logic [7:0] NOTE_03 = 8'h23;
    localparam logic [7:0] NOTE_04 = 8'h21;
    localparam logic [7:0] NOTE_05 = 8'h2A;
    localparam logic [7:0] NOTE_06 = 8'h34;
    localparam logic [7:0] NOTE_07 = 8'h32;
    localparam logic [7:0] NOTE_08 = 8'h33;
    localparam logic [7:0] NOTE_09 = 8'h31;
    localparam logic [7:0] NOTE_10 = 8'h3B;
    localparam logic [7:0] NOTE_11 = 8'h3A;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    function automatic logic [7:0] note_code(input logic [3:0] idx);
        logic [7:0] code;
        case (idx)
            4'd0:    code = NOTE_00;
            4'd1:    code = NOTE_01;
            4'd2:    code = NOTE_02;
            4'd3:    code = NOTE_03;
            4'd4:    code = NOTE_04;
            4'd5:    code = NOTE_05;
            4'd6:    code = NOTE_06;
            4'd7:    code = NOTE_07;
            4'd8:    code = NOTE_08;
            4'd9:    code = NOTE_09;
            4'd10:   code = NOTE_10;
            4'd11:   code = NOTE_11;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 byte receiver, this decoder and the note logic.
interface ps2_scan_decoder_if;
    import ps2_pkg::*;

    logic                 byte_valid;
    logic [7:0]           byte_in;
    logic                 event_valid;
    logic [7:0]           event_code;
    logic                 event_break;
    logic                 event_ext;
    logic [NUM_NOTES-1:0] held_mask;
    logic [7:0]           key_code;
    logic                 key_down;

    modport master (
        output byte_valid, byte_in,
        input  event_valid, event_code, event_break, event_ext,
        input  held_mask, key_code, key_down
    );

    modport slave (
        input  byte_valid, byte_in,
        output event_valid, event_code, event_break, event_ext,
        output held_mask, key_code, key_down
    );

endinterface

// File: rtl/ps2_scan_decoder_lookup.sv
// Combinational note table: scan code -> note index, and held mask -> lowest-index held note code.
module ps2_note_lookup
    import ps2_pkg::*;
(
    input  logic [7:0]           code,
    input  logic [NUM_NOTES-1:0] mask,
    output logic                 hit,
    output logic [3:0]           index,
    output logic [7:0]           lowest_code
);

    always_comb begin
        hit   = 1'b1;
        index = 4'd0;
        case (code)
            NOTE_00: index = 4'd0;
            NOTE_01: index = 4'd1;
            NOTE_02: index = 4'd2;
            NOTE_03: index = 4'd3;
            NOTE_04: index = 4'd4;
            NOTE_05: index = 4'd5;
            NOTE_06: index = 4'd6;
            NOTE_07: index = 4'd7;
            NOTE_08: index = 4'd8;
            NOTE_09: index = 4'd9;
            NOTE_10: index = 4'd10;
            NOTE_11: index = 4'd11;
            default: hit   = 1'b0;
        endcase
    end

    // Scanning from the top down lets the lowest set bit overwrite the others.
    always_comb begin
        lowest_code = 8'h00;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_code = note_code(4'(i));
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-byte decoder: F0/E0 prefix FSM, make/break events, held-note mask and current note.
// Optional prefix-state timeout enabled by defining PS2_PREFIX_TIMEOUT_EN.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
)(
    input  logic               clock,
    input  logic               resetn,
    ps2_scan_decoder_if.slave  bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    ps2_state_t           state, next_state, state_d;
    logic                 is_data, is_ext, is_brk;
    logic                 note_hit, held_hit, emit;
    logic [3:0]           note_index;
    logic [7:0]           fallback_code;
    logic [NUM_NOTES-1:0] note_bit, cleared_mask, held_mask, mask_n;
    logic [7:0]           key_code, key_n;
    logic                 event_valid, event_break, event_ext;
    logic [7:0]           event_code;

    always_comb begin
        next_state = state;
        is_data    = 1'b0;
        is_ext     = 1'b0;
        is_brk     = 1'b0;
        if (bus.byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.byte_in == PS2_EXT)        next_state = ST_EXT;
                    else if (bus.byte_in == PS2_BREAK) next_state = ST_BRK;
                    else                               is_data = 1'b1;
                end
                ST_EXT: begin
                    if (bus.byte_in == PS2_BREAK) next_state = ST_EXT_BRK;
                    else begin
                        is_data    = 1'b1;
                        is_ext     = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_data    = 1'b1;
                    is_brk     = 1'b1;
                    next_state = ST_IDLE;
                end
                default: begin
                    is_data    = 1'b1;
                    is_ext     = 1'b1;
                    is_brk     = 1'b1;
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    assign note_bit     = NUM_NOTES'(1) << note_index;
    assign cleared_mask = held_mask & ~note_bit;
    assign held_hit     = |(held_mask & note_bit);

    ps2_note_lookup u_lookup (
        .code        (bus.byte_in),
        .mask        (cleared_mask),
        .hit         (note_hit),
        .index       (note_index),
        .lowest_code (fallback_code)
    );

    // Note keys are filtered for typematic repeats and stray breaks; everything else always reports.
    always_comb begin
        emit   = 1'b0;
        mask_n = held_mask;
        key_n  = key_code;
        if (is_data) begin
            if (!is_ext && note_hit) begin
                if (!is_brk) begin
                    if (!held_hit) begin
                        emit   = 1'b1;
                        mask_n = held_mask | note_bit;
                        key_n  = bus.byte_in;
                    end
                end else if (held_hit) begin
                    emit   = 1'b1;
                    mask_n = cleared_mask;
                    if (key_code == bus.byte_in) key_n = fallback_code;
                end
            end else begin
                emit = 1'b1;
            end
        end
    end

`ifdef PS2_PREFIX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_count;
    logic             timeout_hit;

    assign timeout_hit = (state != ST_IDLE) && !bus.byte_valid &&
                         (idle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign state_d     = timeout_hit ? ST_IDLE : next_state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            idle_count <= '0;
        else if (state == ST_IDLE || bus.byte_valid || timeout_hit)
            idle_count <= '0;
        else
            idle_count <= idle_count + 1'b1;
    end
`else
    assign state_d = next_state;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            event_valid <= 1'b0;
            event_code  <= 8'h00;
            event_break <= 1'b0;
            event_ext   <= 1'b0;
            held_mask   <= '0;
            key_code    <= 8'h00;
        end else begin
            state       <= state_d;
            event_valid <= emit;
            if (emit) begin
                event_code  <= bus.byte_in;
                event_break <= is_brk;
                event_ext   <= is_ext;
            end
            held_mask <= mask_n;
            key_code  <= key_n;
        end
    end

    assign bus.event_valid = event_valid;
    assign bus.event_code  = event_code;
    assign bus.event_break = event_break;
    assign bus.event_ext   = event_ext;
    assign bus.held_mask   = held_mask;
    assign bus.key_code    = key_code;
    assign bus.key_down    = |held_mask;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Testbench for ps2_scan_decoder: directed keystroke scenarios plus random keystrokes against a key-level model.
module tb_ps2_scan_decoder;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0]  note_tab [12] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
                                   8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A};
    logic [7:0]  other_tab [6] = '{8'h1C, 8'h75, 8'h6B, 8'h29, 8'h5A, 8'h12};
    logic [11:0] m_mask;
    logic [7:0]  m_key;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int note_of(input logic [7:0] code);
        for (int i = 0; i < 12; i++) if (note_tab[i] == code) return i;
        return -1;
    endfunction

    // Key-level model: a press sets a key and makes it current, a release falls back to the lowest held key.
    task automatic model_event(input logic ext, input logic brk, input logic [7:0] code, output logic ev);
        int n;
        n  = note_of(code);
        ev = 1'b1;
        if (!ext && n >= 0) begin
            if (!brk) begin
                if (m_mask[n]) ev = 1'b0;
                else begin
                    m_mask[n] = 1'b1;
                    m_key     = code;
                end
            end else if (!m_mask[n]) begin
                ev = 1'b0;
            end else begin
                m_mask[n] = 1'b0;
                if (m_key == code) begin
                    m_key = 8'h00;
                    for (int i = 11; i >= 0; i--) if (m_mask[i]) m_key = note_tab[i];
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        @(negedge clock);
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, ".event_valid"}, 32'(bus.event_valid), 32'd0);
        check_output({tag, ".held_mask"},   32'(bus.held_mask),   32'(m_mask));
        check_output({tag, ".key_code"},    32'(bus.key_code),    32'(m_key));
    endtask

    task automatic check_event(input logic ev, input logic ext, input logic brk, input logic [7:0] code);
        check_output("event_valid", 32'(bus.event_valid), 32'(ev));
        if (ev) begin
            check_output("event_code",  32'(bus.event_code),  32'(code));
            check_output("event_break", 32'(bus.event_break), 32'(brk));
            check_output("event_ext",   32'(bus.event_ext),   32'(ext));
        end
        check_output("held_mask", 32'(bus.held_mask), 32'(m_mask));
        check_output("key_code",  32'(bus.key_code),  32'(m_key));
        check_output("key_down",  32'(bus.key_down),  32'(|m_mask));
    endtask

    task automatic apply_stimulus(input logic ext, input logic brk, input logic [7:0] code);
        logic ev;
        if (ext) begin
            push(8'hE0);
            check_quiet("after_E0");
        end
        if (brk) begin
            push(8'hF0);
            check_quiet("after_F0");
        end
        push(code);
        model_event(ext, brk, code, ev);
        check_event(ev, ext, brk, code);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            check_quiet("idle");
        end
    endtask

    task automatic check_reset_values();
        check_output("rst.event_valid", 32'(bus.event_valid), 32'd0);
        check_output("rst.event_code",  32'(bus.event_code),  32'd0);
        check_output("rst.event_break", 32'(bus.event_break), 32'd0);
        check_output("rst.event_ext",   32'(bus.event_ext),   32'd0);
        check_output("rst.held_mask",   32'(bus.held_mask),   32'd0);
        check_output("rst.key_code",    32'(bus.key_code),    32'd0);
        check_output("rst.key_down",    32'(bus.key_down),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ev;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        m_mask         = '0;
        m_key          = 8'h00;
        repeat (2) @(negedge clock);
        check_reset_values();
        resetn = 1'b1;
        @(negedge clock);

        // Press and release
        apply_stimulus(1'b0, 1'b0, 8'h1A);
        apply_stimulus(1'b0, 1'b1, 8'h1A);

        // Typematic repeats and fallback to the older held key
        apply_stimulus(1'b0, 1'b0, 8'h1A);
        apply_stimulus(1'b0, 1'b0, 8'h23);
        apply_stimulus(1'b0, 1'b0, 8'h23);
        apply_stimulus(1'b0, 1'b0, 8'h23);
        apply_stimulus(1'b0, 1'b1, 8'h23);
        apply_stimulus(1'b0, 1'b1, 8'h1A);

        // Extended key never touches held state
        apply_stimulus(1'b1, 1'b0, 8'h75);
        apply_stimulus(1'b1, 1'b1, 8'h75);

        // Highest note, released with back-to-back F0/3A
        apply_stimulus(1'b0, 1'b0, 8'h3A);
        apply_stimulus(1'b0, 1'b1, 8'h3A);

        // Stray break of a key that is not held
        apply_stimulus(1'b0, 1'b1, 8'h22);

        for (int k = 0; k < 300; k++) begin
            logic       ext, brk;
            logic [7:0] code;
            if ($urandom_range(0, 3) == 0) code = other_tab[$urandom_range(0, 5)];
            else                           code = note_tab[$urandom_range(0, 11)];
            ext = ($urandom_range(0, 5) == 0);
            brk = $urandom_range(0, 1) == 1;
            apply_stimulus(ext, brk, code);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset between F0 and its data byte
        push(8'hF0);
        check_quiet("pre_reset_F0");
        resetn = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        check_reset_values();
        resetn = 1'b1;
        m_mask = '0;
        m_key  = 8'h00;
        @(negedge clock);
        apply_stimulus(1'b0, 1'b0, 8'h22);
        apply_stimulus(1'b0, 1'b1, 8'h22);

        // Long gap after F0: the timeout build drops the prefix, the default build keeps it
        push(8'hF0);
        check_quiet("timeout_F0");
        idle(16);
        push(8'h22);
`ifdef PS2_PREFIX_TIMEOUT_EN
        model_event(1'b0, 1'b0, 8'h22, ev);
        check_event(ev, 1'b0, 1'b0, 8'h22);
`else
        model_event(1'b0, 1'b1, 8'h22, ev);
        check_event(ev, 1'b0, 1'b1, 8'h22);
`endif
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
